// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit controller:
//   tx_state_t          - frame FSM states
//   LINE_IDLE           - level of the serial line between frames
//   START_BIT, STOP_BIT - framing bit levels
//   DEFAULT_DATA_WIDTH  - default payload width in bits
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

endpackage : uart_tx_pkg

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Payload shift register and bit counter for the UART transmitter.
//   clk      in   bit-rate clock
//   rst      in   asynchronous, active-low reset
//   load     in   capture data into the shift register, clear the counter
//   shift_en in   consume one bit: shift right, count it
//   data     in   parallel payload
//   ser_bit  out  next payload bit to place on the line (shift register LSB)
//   ser_done out  high while the last payload bit is on the line
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ser_bit,
    output logic                  ser_done
);

    // The counter holds how many payload bits have already been handed to the
    // line, so it needs one code beyond DATA_WIDTH-1.
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      cnt;

    // NOTE: clocked state uses non-blocking assignments so every register in
    // the design samples pre-edge values, independent of block ordering.
    // NOTE: the shift register is reset along with the control bits, so an
    // abandoned frame never leaves stale payload behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= data;
            cnt   <= '0;
        end else if (shift_en) begin
            shreg <= shreg >> 1;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign ser_bit  = shreg[0];
    // Once all DATA_WIDTH bits have been shifted out, the last one is the bit
    // currently registered on the line.
    assign ser_done = (cnt == CNT_W'(DATA_WIDTH));

endmodule : uart_tx_serializer

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit controller. One serial bit per clk cycle. Frames a payload as
// start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit.
//   clk        in   bit-rate clock
//   rst        in   asynchronous, active-low reset
//   p_data     in   parallel payload, sampled on acceptance
//   data_valid in   payload request, accepted only while idle
//   par_en     in   parity enable, sampled on acceptance
//   par_bit    in   registered parity from the upstream parity calculator
//   tx_out     out  registered serial line, idles high
//   busy       out  registered, high from the cycle after acceptance through
//                   the stop bit
// -----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_bit,
    output logic                  tx_out,
    output logic                  busy
);

    tx_state_t state;
    logic      par_en_q;
    logic      load;
    logic      shift_en;
    logic      ser_bit;
    logic      ser_done;

    // The outputs are registered, so each edge drives the line value that
    // belongs to the state being entered. A payload bit is consumed on the
    // edge leaving START (bit 0) and on every DATA edge that still has bits.
    assign load     = (state == ST_IDLE) && data_valid;
    assign shift_en = (state == ST_START) || ((state == ST_DATA) && !ser_done);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .data     (p_data),
        .ser_bit  (ser_bit),
        .ser_done (ser_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            tx_out   <= LINE_IDLE;
            busy     <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_valid) begin
                        state    <= ST_START;
                        par_en_q <= par_en;
                        tx_out   <= START_BIT;
                        busy     <= 1'b1;
                    end else begin
                        tx_out <= LINE_IDLE;
                        busy   <= 1'b0;
                    end
                end

                ST_START: begin
                    state  <= ST_DATA;
                    tx_out <= ser_bit;
                end

                ST_DATA: begin
                    if (ser_done) begin
                        if (par_en_q) begin
                            state  <= ST_PARITY;
                            tx_out <= par_bit;
                        end else begin
                            state  <= ST_STOP;
                            tx_out <= STOP_BIT;
                        end
                    end else begin
                        tx_out <= ser_bit;
                    end
                end

                ST_PARITY: begin
                    state  <= ST_STOP;
                    tx_out <= STOP_BIT;
                end

                ST_STOP: begin
                    // busy drops here, so a request seen on this edge is
                    // ignored and the line keeps one idle bit between frames.
                    state  <= ST_IDLE;
                    tx_out <= LINE_IDLE;
                    busy   <= 1'b0;
                end

                default: begin
                    state  <= ST_IDLE;
                    tx_out <= LINE_IDLE;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Self-checking bench for uart_tx_ctrl (DATA_WIDTH = 8). A frame-level model
// turns each accepted request into the list of line bits it must produce and
// is compared against tx_out/busy after every clock edge; directed frames pin
// the model with hand-computed line patterns; a random phase follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int DW = 8;
    localparam int PAR_SLOT = 2;  // queue marker: line shows par_bit here

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic          data_valid = 1'b0;
    logic          par_en = 1'b0;
    logic          par_bit = 1'b0;
    logic          tx_out;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic cap_tx   [0:31];
    logic cap_busy [0:31];

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_bit    (par_bit),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------------------------------------------------------- model
    // Each accepted request becomes a queue of line levels, one per edge.
    int   line_q[$];
    logic exp_tx   = 1'b1;
    logic exp_busy = 1'b0;

    always begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            line_q.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end else begin
            if (line_q.size() == 0 && data_valid && !exp_busy) begin
                line_q.push_back(0);
                for (int i = 0; i < DW; i++) line_q.push_back(int'(p_data[i]));
                if (par_en) line_q.push_back(PAR_SLOT);
                line_q.push_back(1);
            end
            if (line_q.size() > 0) begin
                int v;
                v = line_q.pop_front();
                exp_tx   = (v == PAR_SLOT) ? par_bit : v[0];
                exp_busy = 1'b1;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
            #1;
            check("model_tx_out", 32'(tx_out), 32'(exp_tx));
            check("model_busy", 32'(busy), 32'(exp_busy));
        end
    end

    // -------------------------------------------------------------- helpers
    task automatic start_frame(input logic [DW-1:0] d, input logic pe, input logic pb);
        @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_bit    = pb;
        data_valid = 1'b1;
    endtask

    // Samples the line after each of the next n edges; data_valid drops after
    // the sample at index drop_at.
    task automatic capture(input int n, input int drop_at);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_tx[k]   = tx_out;
            cap_busy[k] = busy;
            if (k == drop_at) data_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] tx_vec(input int n);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v = {v[30:0], cap_tx[k]};
        return v;
    endfunction

    function automatic int busy_count(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(cap_busy[k]);
        return c;
    endfunction

    task automatic idle(input int n);
        data_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int hold_cnt = 0;

        #12;
        check("reset_tx_out", 32'(tx_out), 32'h1);
        check("reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // A5 with parity 0: 0 | 1,0,1,0,0,1,0,1 | 0 | 1 | idle
        start_frame(8'hA5, 1'b1, 1'b0);
        capture(12, 0);
        check("a5_line", tx_vec(12), 32'h52B);
        check("a5_busy_cycles", 32'(busy_count(12)), 32'd11);
        check("a5_idle_after", 32'(cap_busy[11]), 32'h0);

        // 3C without parity: 0 | 0,0,1,1,1,1,0,0 | 1 | idle
        start_frame(8'h3C, 1'b0, 1'b0);
        capture(12, 0);
        check("3c_line", tx_vec(12), 32'h1E7);
        check("3c_busy_cycles", 32'(busy_count(12)), 32'd10);

        // 00 with parity forced to 1: parity slot at E9 must show 1
        start_frame(8'h00, 1'b1, 1'b1);
        capture(12, 0);
        check("par_forced_slot", 32'(cap_tx[9]), 32'h1);
        check("par_forced_line", tx_vec(12), 32'h007);

        // data_valid held high: 01 then FF, parity on, one idle bit between
        start_frame(8'h01, 1'b1, 1'b1);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            cap_tx[k]   = tx_out;
            cap_busy[k] = busy;
            if (k == 0)  p_data = 8'hFF;
            if (k == 11) par_bit = 1'b0;
            if (k == 12) data_valid = 1'b0;
        end
        check("b2b_gap_line", 32'(cap_tx[11]), 32'h1);
        check("b2b_gap_busy", 32'(cap_busy[11]), 32'h0);
        check("b2b_second_start", 32'(cap_tx[12]), 32'h0);
        check("b2b_line", tx_vec(24), 32'h4077FB);
        check("b2b_busy_cycles", 32'(busy_count(24)), 32'd22);

        // Mid-frame request and input changes must not disturb frame 96
        start_frame(8'h96, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            cap_tx[k]   = tx_out;
            cap_busy[k] = busy;
            if (k == 0) data_valid = 1'b0;
            if (k == 4) begin
                data_valid = 1'b1;
                p_data     = 8'h00;
                par_en     = 1'b1;
                par_bit    = 1'b1;
            end
            if (k == 5) data_valid = 1'b0;
            if (k == 7) p_data = 8'hFF;
        end
        check("ignore_line", tx_vec(16), 32'h34FF);
        check("ignore_busy_cycles", 32'(busy_count(16)), 32'd10);

        // Reset mid-DATA, then a clean 5A frame right after release
        start_frame(8'hC3, 1'b1, 1'b0);
        capture(4, 0);
        @(posedge clk);  // E4
        #2;
        rst = 1'b0;
        #1;
        check("midreset_tx_out", 32'(tx_out), 32'h1);
        check("midreset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst        = 1'b1;
        p_data     = 8'h5A;
        par_en     = 1'b0;
        par_bit    = 1'b0;
        data_valid = 1'b1;
        capture(12, 0);
        check("postreset_line", tx_vec(12), 32'h2D7);
        check("postreset_busy_cycles", 32'(busy_count(12)), 32'd10);

        // Random traffic, occasional held requests and resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                #1;
                check("rand_reset_tx_out", 32'(tx_out), 32'h1);
                check("rand_reset_busy", 32'(busy), 32'h0);
                @(negedge clk);
                rst = 1'b1;
            end
            if (hold_cnt > 0) begin
                hold_cnt--;
            end else if ($urandom_range(0, 9) == 0) begin
                hold_cnt   = $urandom_range(5, 30);
                data_valid = 1'b1;
            end else begin
                data_valid = ($urandom_range(0, 4) == 0);
            end
            p_data = DW'($urandom);
            par_en = 1'($urandom);
            if (!busy) par_bit = 1'($urandom);
        end
        idle(15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule : tb_uart_tx_ctrl
